keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans the 4x4 active-low button matrix and delivers a debounced 16-bit button vector to the CPU `buttons` input.
- Also delivers a queued valid/ready stream of key-press events for event-driven consumers.
- Sits directly upstream of the processor and replaces the free-running column rotate and row sampling in the board top level.

Parameters:
- SCAN_DIV, 16384: clk cycles each column is driven. Must be a power of two, >= 4.
- SAMPLE_AT, SCAN_DIV/2: divider count at which rows are sampled (settling time). Range 2..SCAN_DIV-1.
- DEBOUNCE_SCANS, 4: consecutive full frames a raw key state must disagree with `buttons` before `buttons` changes. Minimum 1.

Ports:
- clk  input  1: system clock.
- rst_n  input  1: asynchronous active-low reset.
- col_n  output  4: column drive, one-cold.
- row_n  input  4: row sense, active-low, externally pulled up, asynchronous to clk.
- buttons  output  16: debounced key state; bit index = 4*row + column.
- key_valid  output  1: a press event is presented.
- key_code  output  4: index of the presented key.
- key_ready  input  1: consumer accepts the event.
- overrun  output  1: sticky; a press was lost.

Behaviour:
- Reset (asynchronous, immediate):
  - col_n=4'b1110, buttons=0, key_valid=0, key_code=0, overrun=0.
  - Divider=0, column index=0, raw=0, pending=0, all debounce counters=0.
  - Both row synchroniser stages=4'b1111.
- Row synchroniser: row_n passes through a 2-flop synchroniser; only the synchronised value is used.
- Divider and column drive:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - At count SCAN_DIV-1, the column index advances 0→1→2→3→0; col_n has bit[index]=0 and the others 1.
  - Sequence: 1110, 1101, 1011, 0111.
- Sampling: at count SAMPLE_AT, raw[4*r + c] <= !sync_row[r] for r=0..3, where c is the current column index.
- Frame end: the cycle with count SCAN_DIV-1 and column 3, i.e. every 4*SCAN_DIV cycles. All debounce evaluation happens only on this cycle.
- Debounce, per key k, at frame end:
  - If raw[k]==buttons[k]: cnt[k] <= 0.
  - Else if cnt[k]==DEBOUNCE_SCANS-1: buttons[k] <= raw[k] and cnt[k] <= 0.
  - Else: cnt[k] <= cnt[k]+1.
  - Counter width is $clog2(DEBOUNCE_SCANS) with a minimum of 1.
- Press detection: a 0→1 transition of buttons[k] sets pending[k] on the cycle after buttons updates. Releases generate no event.
- Event output (valid/ready):
  - A handshake occurs when key_valid && key_ready.
  - If key_valid==0 or a handshake occurs, and pending != 0: load key_code = lowest set index of pending, set key_valid=1, clear that pending bit, all in the same cycle.
  - If a handshake occurs and pending==0: key_valid <= 0.
  - While key_valid && !key_ready, key_code is held stable.
  - Maximum throughput: one event per cycle.
- Simultaneous set and clear of the same pending bit: the set wins.
- Overrun:
  - Set when a new press of key k arrives while pending[k] is already 1.
  - The new press is dropped, because pending is a set.
  - Overrun is cleared only by rst_n.
  - A press of the key currently presented on key_code, with pending[k]=0, is not an overrun; it re-queues.
- Latency from a stable press to buttons: ≤ 2 + 4*SCAN_DIV*(DEBOUNCE_SCANS+1) cycles. key_valid follows buttons after 2 further cycles.
- Multiple keys per frame: supported, no ghost suppression. Events drain in ascending index order.

Test Plan (SCAN_DIV=8, SAMPLE_AT=4, DEBOUNCE_SCANS=3, frame=32 cycles):
- Reset test:
  - Stimulus: assert rst_n=0 mid-run, then release.
  - Required: all outputs take reset values with no clk edge. After release, col_n goes 1110,1101,1011,0111 with each step exactly 8 cycles, then repeats.
- Clean press:
  - Stimulus: drive row_n[1]=0 whenever col_n==1011 (key 6), with key_ready=1.
  - Required: buttons[6] rises at the end of the 3rd frame in which key 6 is sampled. key_valid=1 with key_code=6 for exactly 1 cycle. Holding the key produces no further events.
- Bounce:
  - Stimulus: key 6 present for 2 frames, then released.
  - Required: buttons stays 0 and key_valid stays 0.
  - Stimulus: release a held key for 2 frames only.
  - Required: buttons stays 1.
- Backpressure:
  - Stimulus: key_ready=0; keys 3 and 12 pressed together.
  - Required: key_code=3 with key_valid held. After key_ready=1: the next cycle shows key_code=12, then key_valid=0.
- Overrun:
  - Stimulus: key_ready=0; press key 0, then key 5, then release and re-press key 5 (each debounced).
  - Required: overrun=1 and stays 1. The drained event sequence is 0, 5 only.
- Asynchronous row noise:
  - Stimulus: toggle row_n at random phases relative to clk while SAMPLE_AT is not being reached.
  - Required: raw is unaffected.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces it into a
// 16-bit button vector and queues key-press events on a valid/ready port.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   col_n[3:0]          one-cold column drive
//   row_n[3:0]          active-low row sense (asynchronous)
//   buttons[15:0]       debounced state, bit = 4*row + col
//   key_valid/key_code  press event, held until key_ready
//   key_ready           consumer accepts the event
//   overrun             sticky, a press was dropped
module keypad_scanner #(
   parameter int SCAN_DIV       = 16384,
   parameter int SAMPLE_AT      = SCAN_DIV / 2,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  col_n,
   input  logic [3:0]  row_n,
   output logic [15:0] buttons,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ready,
   output logic        overrun
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW =
      (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIV_SAMP = DW'(SAMPLE_AT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

   logic [3:0]    sync1, sync2;
   logic [DW-1:0] div;
   logic [1:0]    col;
   logic [15:0]   raw, raw_nx;
   logic [15:0]   btn_q, btn_nx;
   logic [15:0]   pending, pending_nx;
   logic [15:0]   rise, clr;
   logic [CW-1:0] cnt    [16];
   logic [CW-1:0] cnt_nx [16];
   logic [3:0]    sel;
   logic          div_last, frame_end, take, load;

   assign div_last  = (div == DIV_LAST);
   assign frame_end = div_last && (col == 2'd3);
   assign col_n     = ~(4'b0001 << col);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 4'b1111;
         sync2 <= 4'b1111;
      end else begin
         sync1 <= row_n;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         col <= '0;
      end else begin
         div <= div_last ? '0 : div + 1'b1;
         if (div_last)
            col <= col + 1'b1;
      end
   end

   // Only the four keys of the driven column are refreshed per sample.
   always_comb begin
      raw_nx = raw;
      for (int r = 0; r < 4; r++)
         raw_nx[{2'(r), col}] = ~sync2[r];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         raw <= '0;
      else if (div == DIV_SAMP)
         raw <= raw_nx;
   end

   always_comb begin
      btn_nx = buttons;
      for (int k = 0; k < 16; k++)
         cnt_nx[k] = cnt[k];
      if (frame_end) begin
         for (int k = 0; k < 16; k++) begin
            if (raw[k] == buttons[k]) begin
               cnt_nx[k] = '0;
            end else if (cnt[k] == CNT_LAST) begin
               btn_nx[k] = raw[k];
               cnt_nx[k] = '0;
            end else begin
               cnt_nx[k] = cnt[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buttons <= '0;
         btn_q   <= '0;
         for (int k = 0; k < 16; k++)
            cnt[k] <= '0;
      end else begin
         buttons <= btn_nx;
         btn_q   <= buttons;
         for (int k = 0; k < 16; k++)
            cnt[k] <= cnt_nx[k];
      end
   end

   assign rise = buttons & ~btn_q;
   assign take = !key_valid || key_ready;
   assign load = take && (|pending);

   always_comb begin
      sel = '0;
      for (int i = 15; i >= 0; i--)
         if (pending[i])
            sel = 4'(i);
   end

   // A fresh press of the key being popped this cycle re-queues.
   assign clr        = load ? (16'd1 << sel) : '0;
   assign pending_nx = (pending & ~clr) | rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         overrun   <= 1'b0;
      end else begin
         pending <= pending_nx;
         if (|(rise & pending & ~clr))
            overrun <= 1'b1;
         if (load) begin
            key_valid <= 1'b1;
            key_code  <= sel;
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule
